pe_result_drain: RTL and testbench

Result collection stage placed directly after the per-PE block-floating-point accumulator. It regenerates the result-valid strobe by delaying the accumulator's flush signal by the accumulator latency, and captures each completed result when that strobe fires. Each captured result is canonicalised, with optional ReLU, and buffered in a small show-ahead FIFO. The FIFO drains to the array output bus through a valid/ready handshake, and results that arrive while the FIFO is full are reported through a sticky overflow flag.

---
 rtl/pe_result_drain.sv | 106 ++++++++++
 tb/tb_pe_result_drain.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pe_result_drain.sv
// Result drain stage behind the per-PE accumulator: rebuilds the result strobe from the
// delayed flush, canonicalises each captured result and buffers it in a show-ahead FIFO.
module pe_result_drain #(
  parameter int RESULT_WIDTH          = 16,
  parameter int RESULT_EXPONENT_WIDTH = 5,
  parameter int ACCUM_LATENCY         = 6,
  parameter int FIFO_DEPTH            = 4,
  parameter int RELU_ENABLE           = 0
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          i_flush_accumulator,
  input  logic [RESULT_WIDTH-1:0]       i_result,
  output logic [RESULT_WIDTH-1:0]       o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overflow,
  input  logic                          i_clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ACCUM_LATENCY-1:0] dly_q, dly_d;
  logic [RESULT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     ovf_q, ovf_d;
  logic [RESULT_WIDTH-1:0]  canon_s;
  logic                     cap_s, full_s, pop_s, push_s, drop_s;

  // Flush delay line: its last stage lines up with the accumulator's final result.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = i_flush_accumulator;
    for (int i = 1; i < ACCUM_LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  assign cap_s = dly_q[ACCUM_LATENCY-1];

  // Zero exponent means zero (drops the sign of -0); optional ReLU clamps negatives.
  always_comb begin
    canon_s = i_result;
    if (i_result[RESULT_WIDTH-2 -: RESULT_EXPONENT_WIDTH] == '0) begin
      canon_s = '0;
    end else if ((RELU_ENABLE != 0) && i_result[RESULT_WIDTH-1]) begin
      canon_s = '0;
    end else begin
      canon_s = i_result;
    end
  end

  assign full_s  = (level_q == LVL_W'(FIFO_DEPTH));
  assign o_valid = (level_q != '0);
  assign pop_s   = o_valid && i_ready;
  assign push_s  = cap_s && (!full_s || pop_s);
  assign drop_s  = cap_s && full_s && !pop_s;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_level = level_q;
  assign o_overflow = ovf_q;

  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (i_clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dly_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      dly_q   <= dly_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= canon_s;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: two instances (ReLU off/on) share stimulus; a reference
// model fills scoreboard queues and a negedge monitor checks every output.
module tb_pe_result_drain;

  localparam int L    = 6;
  localparam int D    = 4;
  localparam int MAXC = 4096;

  logic        clock, resetn, i_flush, i_ready, i_clr;
  logic [15:0] i_result;
  logic [15:0] o_data0, o_data1;
  logic        o_valid0, o_valid1, o_ovf0, o_ovf1;
  logic [2:0]  o_level0, o_level1;

  pe_result_drain #(.RESULT_WIDTH(16), .RESULT_EXPONENT_WIDTH(5), .ACCUM_LATENCY(L),
                    .FIFO_DEPTH(D), .RELU_ENABLE(0)) dut0 (
    .clock(clock), .resetn(resetn), .i_flush_accumulator(i_flush), .i_result(i_result),
    .o_data(o_data0), .o_valid(o_valid0), .i_ready(i_ready), .o_overflow(o_ovf0),
    .i_clear_overflow(i_clr), .o_level(o_level0));

  pe_result_drain #(.RESULT_WIDTH(16), .RESULT_EXPONENT_WIDTH(5), .ACCUM_LATENCY(L),
                    .FIFO_DEPTH(D), .RELU_ENABLE(1)) dut1 (
    .clock(clock), .resetn(resetn), .i_flush_accumulator(i_flush), .i_result(i_result),
    .o_data(o_data1), .o_valid(o_valid1), .i_ready(i_ready), .o_overflow(o_ovf1),
    .i_clear_overflow(i_clr), .o_level(o_level1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rst_cyc = -1;
  int          m_level = 0;
  bit          m_ovf   = 1'b0;
  bit          flush_at [MAXC];
  logic [15:0] val_at   [MAXC];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] canon(input logic [15:0] v, input bit relu);
    if (v[14:10] == 5'd0) return 16'h0000;
    if (relu && v[15]) return 16'h0000;
    return v;
  endfunction

  // One clock cycle: drive inputs, let the edge happen, then advance the reference model.
  task automatic step(input bit f, input bit rdy, input bit clr, input logic [15:0] v);
    bit          cap;
    logic [15:0] cv;
    bit          full, pop, push, drop;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    flush_at[cyc] = f;
    val_at[cyc]   = v;
    cap = (cyc >= L) && flush_at[cyc-L] && ((cyc - L) > rst_cyc);
    cv  = cap ? val_at[cyc-L] : 16'($urandom);
    i_flush  = f;
    i_ready  = rdy;
    i_clr    = clr;
    i_result = cv;
    @(posedge clock);
    #1;
    full = (m_level == D);
    pop  = (m_level != 0) && rdy;
    push = cap && (!full || pop);
    drop = cap && full && !pop;
    if (push) begin
      exp0.push_back(canon(cv, 1'b0));
      exp1.push_back(canon(cv, 1'b1));
    end
    m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic pulse_reset();
    i_flush = 1'b0;
    flush_at[cyc] = 1'b0;
    resetn  = 1'b0;
    rst_cyc = cyc;
    m_level = 0;
    m_ovf   = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    chk("rst_valid0", {31'd0, o_valid0}, 32'd0);
    chk("rst_valid1", {31'd0, o_valid1}, 32'd0);
    chk("rst_level0", {29'd0, o_level0}, 32'd0);
    chk("rst_level1", {29'd0, o_level1}, 32'd0);
    chk("rst_data0",  {16'd0, o_data0},  32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cyc++;
  endtask

  // Monitor: state outputs against the model, data against the scoreboard on each pop.
  always @(negedge clock) begin
    chk("level0", {29'd0, o_level0}, 32'(m_level));
    chk("level1", {29'd0, o_level1}, 32'(m_level));
    chk("ovf0",   {31'd0, o_ovf0},   {31'd0, m_ovf});
    chk("ovf1",   {31'd0, o_ovf1},   {31'd0, m_ovf});
    chk("valid0", {31'd0, o_valid0}, {31'd0, (m_level != 0)});
    chk("valid1", {31'd0, o_valid1}, {31'd0, (m_level != 0)});
    if (o_valid0 && i_ready) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL data0 actual=%0h required=<none>", o_data0);
      end else chk("data0", {16'd0, o_data0}, {16'd0, exp0.pop_front()});
    end
    if (o_valid1 && i_ready) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL data1 actual=%0h required=<none>", o_data1);
      end else chk("data1", {16'd0, o_data1}, {16'd0, exp1.pop_front()});
    end
  end

  logic [15:0] fill_vals [5];
  logic [15:0] rv;

  initial begin
    fill_vals[0] = 16'h3C00; fill_vals[1] = 16'h4000; fill_vals[2] = 16'h4200;
    fill_vals[3] = 16'h4400; fill_vals[4] = 16'h4500;
    resetn = 1'b0; i_flush = 1'b0; i_ready = 1'b0; i_clr = 1'b0; i_result = 16'h0;
    #1;
    chk("init_valid0", {31'd0, o_valid0}, 32'd0);
    chk("init_data0",  {16'd0, o_data0},  32'd0);
    chk("init_ovf0",   {31'd0, o_ovf0},   32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    // Single pass-through result
    for (int i = 0; i < 20; i++) step(i == 10, 1'b1, 1'b0, 16'h3C00);

    // Canonicalisation: -0, negative, positive, across both ReLU settings
    for (int i = 0; i < 30; i++)
      step(i == 0 || i == 3 || i == 6 || i == 9, 1'b1, 1'b0,
           (i == 0) ? 16'h8000 : (i == 3) ? 16'hC000 : (i == 6) ? 16'h4000 : 16'h0000);

    // Fill and overflow with the consumer stalled, then drain
    for (int i = 0; i < 14; i++) step(i < 5, 1'b0, 1'b0, (i < 5) ? fill_vals[i] : 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 16'h0);

    // Full FIFO, capture coincides with a pop
    for (int i = 0; i < 12; i++) step(i < 4, 1'b0, 1'b0, fill_vals[i % 4]);
    for (int i = 0; i < 14; i++) step(i == 0, i >= L, 1'b0, 16'h4600);

    // Clear and drop in the same cycle, then clear alone
    for (int i = 0; i < 12; i++) step(i < 4, 1'b0, 1'b0, fill_vals[i % 4]);
    for (int i = 0; i < 10; i++) step(i == 0, 1'b0, i == L, 16'h4700);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // Reset with results buffered and flushes in flight
    for (int i = 0; i < 9; i++) step(i < 2, 1'b0, 1'b0, 16'h4800);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h4900);
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 4) == 0) rv[14:10] = 5'd0;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, rv);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("drained0", 32'(exp0.size()), 32'd0);
    chk("drained1", 32'(exp1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
